stream_demux: RTL and testbench
===============================

// Module: stream_demux
// PURPOSE
//  One-to-many counterpart of the N:1 mux. Steers one valid/ready input stream
//  to one of OUTPUT_BUS_COUNT output channels, chosen by a per-beat selection.
//  Each channel has a one-entry registered holding slot, so channels stall independently.
//  Used to dispatch pipeline results or requests to parallel consumers (functional units, write ports).
// PARAMETERS
//  WIDTH             32  data bits per beat
//  OUTPUT_BUS_COUNT  4   number of output channels; legal range >=2; need not be a power of 2
// PORTS
//  clk               in   1                      single clock, rising edge
//  reset             in   1                      synchronous, active-high
//  in_valid          in   1                      input beat present
//  in_ready          out  1                      beat accepted when in_valid && in_ready at posedge
//  selection         in   $clog2(OUTPUT_BUS_COUNT)  target channel for current beat
//  in_data           in   WIDTH                  input payload
//  out_valid         out  OUTPUT_BUS_COUNT       per-channel slot full
//  out_ready         in   OUTPUT_BUS_COUNT       per-channel consumer ready
//  out_data          out  WIDTH x OUTPUT_BUS_COUNT  unpacked array, one payload per channel
//  select_error      out  1                      1-cycle pulse: beat with out-of-range selection was dropped
// BEHAVIOUR
//  Reset (sync, active-high): all slots empty; out_valid=0, out_data[*]=0, select_error=0.
//   Reset asserted mid-transfer discards held beats; no beat is accepted in a reset cycle.
//  Per channel i: state EMPTY/FULL (out_valid[i]), data register out_data[i].
//   EMPTY -> FULL : input accepted with selection==i.
//   FULL -> EMPTY : out_ready[i] && no new accept for i.
//   FULL -> FULL  : out_ready[i] && new accept for i (slot reloaded, no bubble).
//   FULL hold     : !out_ready[i]; out_data[i] stays stable until the handshake completes.
//  in_ready (combinational, independent of in_valid):
//   selection < OUTPUT_BUS_COUNT : in_ready = !out_valid[selection] || out_ready[selection].
//   selection >= OUTPUT_BUS_COUNT: in_ready = 1; the accepted beat is discarded; select_error=1 the next cycle.
//  Latency: beat accepted at edge k appears on out_valid/out_data of its channel after edge k (registered).
//  Throughput: 1 beat/cycle into any channel whose consumer holds out_ready high.
//  Ordering: FIFO order is preserved per channel; there is no ordering between channels.
//  A stall on channel j never blocks a beat selected for channel i!=j.
//  No combinational path from in_valid or in_data to any output; out_ready->in_ready is combinational.
//  Protocol (asserted in bench): while in_valid && !in_ready, in_data and selection must hold stable.
//  out_data of an empty slot retains its last value (don't-care); only out_valid qualifies it.
// TESTING
//  1 reset: hold reset 2 cycles mid-stream with slot 2 FULL -> out_valid=0, out_data all 0, select_error=0.
//  2 streaming: sel=1, data 0xA0..0xA7 back-to-back, out_ready[1]=1 -> 8 beats on ch1, 1-cycle latency, in_ready=1 throughout.
//  3 backpressure: ch0 out_ready=0, send 0x11 then 0x22 to ch0 -> 0x11 held stable, in_ready=0 on 0x22;
//    raising out_ready[0] drains 0x11, 0x22 is accepted the same cycle, 0x22 appears the next cycle.
//  4 independence: ch0 stalled FULL; send 0x33 to ch3 -> accepted immediately, out_valid[3]=1 next cycle, ch0 unchanged.
//  5 bad select (OUTPUT_BUS_COUNT=3): sel=3, data 0x55 -> in_ready=1, select_error pulses 1 cycle, no out_valid change.
//  6 random: random valid/sel/out_ready for 10k cycles vs scoreboard -> per-channel order intact, no loss or duplication.

Source files
------------

// File: rtl/stream_demux.sv
// One-to-many stream steering: each accepted beat is parked in the one-entry
// slot of the channel named by its selection, so channels drain independently.
module stream_demux #(
  parameter int WIDTH            = 32,
  parameter int OUTPUT_BUS_COUNT = 4,
  localparam int SEL_W           = (OUTPUT_BUS_COUNT > 1) ? $clog2(OUTPUT_BUS_COUNT) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SEL_W-1:0]            selection,
  input  logic [WIDTH-1:0]            in_data,
  output logic [OUTPUT_BUS_COUNT-1:0] out_valid,
  input  logic [OUTPUT_BUS_COUNT-1:0] out_ready,
  output logic [WIDTH-1:0]            out_data [OUTPUT_BUS_COUNT],
  output logic                        select_error
);

  localparam int SEL_SPAN = 1 << SEL_W;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  logic [OUTPUT_BUS_COUNT-1:0] slot_full;
  logic [SEL_SPAN-1:0]         can_take;
  logic [SEL_SPAN-1:0]         chan_exists;
  logic                        accept;
  logic                        in_range;
  logic                        select_error_d;
  logic                        select_error_q;

  // Selection codes past the last channel always accept, so bad beats never stall the input.
  genvar gi;
  generate
    for (gi = 0; gi < SEL_SPAN; gi++) begin : g_code
      if (gi < OUTPUT_BUS_COUNT) begin : g_real
        assign can_take[gi]    = !slot_full[gi] || out_ready[gi];
        assign chan_exists[gi] = 1'b1;
      end else begin : g_phantom
        assign can_take[gi]    = 1'b1;
        assign chan_exists[gi] = 1'b0;
      end
    end
  endgenerate

  assign in_ready = can_take[selection];
  assign in_range = chan_exists[selection];
  assign accept   = in_valid && in_ready && !reset;

  generate
    for (gi = 0; gi < OUTPUT_BUS_COUNT; gi++) begin : g_chan
      slot_state_t      state_q;
      slot_state_t      state_d;
      logic [WIDTH-1:0] data_q;
      logic [WIDTH-1:0] data_d;
      logic             load;

      assign load = accept && (selection == SEL_W'(gi));

      always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (state_q == SLOT_EMPTY) begin
          if (load) begin
            state_d = SLOT_FULL;
            data_d  = in_data;
          end
        end else if (out_ready[gi]) begin
          // Drain and refill in the same cycle keeps the channel at full rate.
          if (load) begin
            state_d = SLOT_FULL;
            data_d  = in_data;
          end else begin
            state_d = SLOT_EMPTY;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= SLOT_EMPTY;
          data_q  <= '0;
        end else begin
          state_q <= state_d;
          data_q  <= data_d;
        end
      end

      assign slot_full[gi] = (state_q == SLOT_FULL);
      assign out_valid[gi] = slot_full[gi];
      assign out_data[gi]  = data_q;
    end
  endgenerate

  always_comb begin
    select_error_d = accept && !in_range;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      select_error_q <= 1'b0;
    end else begin
      select_error_q <= select_error_d;
    end
  end

  assign select_error = select_error_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-channel and a 3-channel instance, directed
// scenarios with literal expectations plus a per-channel FIFO reference model.
module tb_stream_demux;

  logic clk;
  logic reset;

  // index 0 -> 4-channel instance, index 1 -> 3-channel instance
  logic        iv   [2];
  logic [1:0]  sel  [2];
  logic [31:0] din  [2];
  logic [3:0]  ordy [2];
  logic        ir   [2];
  logic        se   [2];
  logic [3:0]  ov   [2];

  logic [3:0]  ov4;
  logic [2:0]  ov3;
  logic [31:0] od4 [4];
  logic [31:0] od3 [3];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stream_demux #(.WIDTH(32), .OUTPUT_BUS_COUNT(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(iv[0]), .in_ready(ir[0]), .selection(sel[0]), .in_data(din[0]),
    .out_valid(ov4), .out_ready(ordy[0]), .out_data(od4), .select_error(se[0])
  );

  stream_demux #(.WIDTH(32), .OUTPUT_BUS_COUNT(3)) dut3 (
    .clk(clk), .reset(reset),
    .in_valid(iv[1]), .in_ready(ir[1]), .selection(sel[1]), .in_data(din[1]),
    .out_valid(ov3), .out_ready(ordy[1][2:0]), .out_data(od3), .select_error(se[1])
  );

  assign ov[0] = ov4;
  assign ov[1] = {1'b0, ov3};

  function automatic logic [31:0] odat(input int k, input int ch);
    if (k == 0) return od4[ch];
    if (ch < 3) return od3[ch];
    return 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each channel is a FIFO of capacity one; ready when empty or draining.
  logic [31:0] q [2][4][$];
  logic        m_err      [2];
  logic        prev_stall [2];
  logic [1:0]  prev_sel   [2];
  logic [31:0] prev_din   [2];
  int          delivered  [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 1'b0; prev_stall[k] = 1'b0; delivered[k] = 0;
      prev_sel[k] = '0; prev_din[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int   n;
        logic exp_ready;
        n = (k == 0) ? 4 : 3;
        if (prev_stall[k]) begin
          chk($sformatf("proto_sel[%0d]", k), 32'(sel[k]), 32'(prev_sel[k]));
          chk($sformatf("proto_data[%0d]", k), din[k], prev_din[k]);
        end
        for (int ch = 0; ch < n; ch++) begin
          chk($sformatf("m_valid[%0d][%0d]", k, ch), 32'(ov[k][ch]), 32'(q[k][ch].size() != 0));
          if (q[k][ch].size() != 0)
            chk($sformatf("m_data[%0d][%0d]", k, ch), odat(k, ch), q[k][ch][0]);
        end
        chk($sformatf("m_sel_err[%0d]", k), 32'(se[k]), 32'(m_err[k]));
        if (int'(sel[k]) >= n) exp_ready = 1'b1;
        else exp_ready = (q[k][sel[k]].size() == 0) || ordy[k][sel[k]];
        chk($sformatf("m_in_ready[%0d]", k), 32'(ir[k]), 32'(exp_ready));

        prev_stall[k] = iv[k] && !exp_ready && !reset;
        prev_sel[k]   = sel[k];
        prev_din[k]   = din[k];
        if (reset) begin
          for (int ch = 0; ch < 4; ch++) q[k][ch].delete();
          m_err[k] = 1'b0;
        end else begin
          for (int ch = 0; ch < n; ch++) begin
            if (q[k][ch].size() != 0 && ordy[k][ch]) begin
              void'(q[k][ch].pop_front());
              delivered[k]++;
            end
          end
          m_err[k] = 1'b0;
          if (iv[k] && exp_ready) begin
            if (int'(sel[k]) < n) q[k][sel[k]].push_back(din[k]);
            else m_err[k] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic hold [2];
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; sel[k] = '0; din[k] = '0; ordy[k] = '0;
    end
    step(); step(); step();
    reset = 1'b0;

    // Reset mid-stream with slot 2 full
    iv[0] = 1'b1; sel[0] = 2'd2; din[0] = 32'hC2;
    step();
    iv[0] = 1'b0;
    @(negedge clk);
    chk("t1_pre_valid2", 32'(ov4[2]), 32'h1);
    chk("t1_pre_data2", od4[2], 32'hC2);
    step();
    reset = 1'b1; iv[0] = 1'b1; sel[0] = 2'd1; din[0] = 32'hDEAD; ordy[0] = 4'b0010;
    step();
    step();
    reset = 1'b0; iv[0] = 1'b0; ordy[0] = 4'b0000;
    @(negedge clk);
    chk("t1_valid", 32'(ov4), 32'h0);
    for (int ch = 0; ch < 4; ch++) chk($sformatf("t1_data%0d", ch), od4[ch], 32'h0);
    chk("t1_sel_err", 32'(se[0]), 32'h0);
    step();

    // Back-to-back streaming into channel 1
    ordy[0] = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      iv[0] = 1'b1; sel[0] = 2'd1; din[0] = 32'hA0 + 32'(i);
      @(negedge clk);
      chk($sformatf("t2_in_ready%0d", i), 32'(ir[0]), 32'h1);
      if (i > 0) begin
        chk($sformatf("t2_valid%0d", i), 32'(ov4[1]), 32'h1);
        chk($sformatf("t2_data%0d", i), od4[1], 32'hA0 + 32'(i - 1));
      end
      step();
    end
    iv[0] = 1'b0;
    @(negedge clk);
    chk("t2_last_data", od4[1], 32'hA7);
    step();
    @(negedge clk);
    chk("t2_drained", 32'(ov4[1]), 32'h0);
    step();

    // Backpressure on channel 0
    ordy[0] = 4'b0000;
    iv[0] = 1'b1; sel[0] = 2'd0; din[0] = 32'h11;
    @(negedge clk);
    chk("t3_ready_first", 32'(ir[0]), 32'h1);
    step();
    din[0] = 32'h22;
    @(negedge clk);
    chk("t3_held_data", od4[0], 32'h11);
    chk("t3_ready_stall", 32'(ir[0]), 32'h0);
    step();
    @(negedge clk);
    chk("t3_still_held", od4[0], 32'h11);
    chk("t3_still_stall", 32'(ir[0]), 32'h0);
    step();
    ordy[0] = 4'b0001;
    @(negedge clk);
    chk("t3_ready_release", 32'(ir[0]), 32'h1);
    step();
    iv[0] = 1'b0; ordy[0] = 4'b0000;
    @(negedge clk);
    chk("t3_reload_valid", 32'(ov4[0]), 32'h1);
    chk("t3_reload_data", od4[0], 32'h22);
    step();

    // Channel 3 proceeds while channel 0 is stalled
    iv[0] = 1'b1; sel[0] = 2'd3; din[0] = 32'h33;
    @(negedge clk);
    chk("t4_ready", 32'(ir[0]), 32'h1);
    step();
    iv[0] = 1'b0;
    @(negedge clk);
    chk("t4_valid3", 32'(ov4[3]), 32'h1);
    chk("t4_data3", od4[3], 32'h33);
    chk("t4_valid0", 32'(ov4[0]), 32'h1);
    chk("t4_data0", od4[0], 32'h22);
    step();
    ordy[0] = 4'b1111;
    step();
    step();
    @(negedge clk);
    chk("t4_drained", 32'(ov4), 32'h0);
    step();
    ordy[0] = 4'b0000;

    // Out-of-range selection on the 3-channel instance
    iv[1] = 1'b1; sel[1] = 2'd3; din[1] = 32'h55;
    @(negedge clk);
    chk("t5_ready", 32'(ir[1]), 32'h1);
    chk("t5_err_before", 32'(se[1]), 32'h0);
    step();
    iv[1] = 1'b0;
    @(negedge clk);
    chk("t5_err_pulse", 32'(se[1]), 32'h1);
    chk("t5_no_valid", 32'(ov3), 32'h0);
    step();
    @(negedge clk);
    chk("t5_err_clear", 32'(se[1]), 32'h0);
    step();

    // Randomised traffic on both instances, checked by the reference model
    for (int k = 0; k < 2; k++) delivered[k] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) hold[k] = iv[k] && !ir[k];
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 599) == 0);
      for (int k = 0; k < 2; k++) begin
        if (!hold[k]) begin
          iv[k]  = ($urandom_range(0, 3) != 0);
          sel[k] = 2'($urandom_range(0, 3));
          din[k] = $urandom;
        end
        ordy[k] = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      end
    end
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 4'b1111;
    end
    step(); step(); step();
    @(negedge clk);
    chk("t6_traffic4", 32'(delivered[0] > 1000), 32'h1);
    chk("t6_traffic3", 32'(delivered[1] > 1000), 32'h1);
    chk("t6_empty4", 32'(ov4), 32'h0);
    chk("t6_empty3", 32'(ov3), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
